// File: rtl/universal_shift_reg_n.sv
// universal_shift_reg_n
//   Parametrised universal shift register with hold, shift-right, shift-left,
//   parallel-load and rotate modes, serial cascade outputs and an autonomous
//   burst-shift engine (one START shifts the register CNT times).
//
//   Optional feature macro: USR_PARITY_EN (adds the PAR output, PAR = ^Q).
//
// Ports
//   CP     in   1      clock, rising edge
//   CR     in   1      asynchronous reset, active-high
//   S      in   2      mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   SR     in   1      serial in, enters MSB on shift right
//   SL     in   1      serial in, enters LSB on shift left
//   ROT    in   1      1: rotate (wrapped bit replaces SR/SL)
//   D      in   WIDTH  parallel load data
//   START  in   1      burst request, sampled in IDLE only
//   CNT    in   CNT_W  burst shift count
//   Q      out  WIDTH  register contents
//   QR     out  1      serial out right (Q[0])
//   QL     out  1      serial out left (Q[WIDTH-1])
//   BUSY   out  1      burst in progress
//   PAR    out  1      even-parity of Q (USR_PARITY_EN only)
//   DONE   out  1      one-cycle burst-complete pulse
module universal_shift_reg_n #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             CP,
   input  logic             CR,
   input  logic [1:0]       S,
   input  logic             SR,
   input  logic             SL,
   input  logic             ROT,
   input  logic [WIDTH-1:0] D,
   input  logic             START,
   input  logic [CNT_W-1:0] CNT,
   output logic [WIDTH-1:0] Q,
   output logic             QR,
   output logic             QL,
   output logic             BUSY,
`ifdef USR_PARITY_EN
   output logic             PAR,
`endif
   output logic             DONE
);

   localparam logic [1:0] ModeHold  = 2'b00;
   localparam logic [1:0] ModeRight = 2'b01;
   localparam logic [1:0] ModeLeft  = 2'b10;
   localparam logic [1:0] ModeLoad  = 2'b11;

   typedef enum logic {StIdle, StRun} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               dir_left_q, dir_left_d;
   logic               rot_q, rot_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic               done_q, done_d;

   // One shift step; with rot set the bit falling off one end re-enters the other.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] q,
                                                   input logic             left,
                                                   input logic             rot,
                                                   input logic             sr,
                                                   input logic             sl);
      logic [WIDTH-1:0] r;
      if (left) begin
         r = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : sl)};
      end else begin
         r = {(rot ? q[0] : sr), q[WIDTH-1:1]};
      end
      return r;
   endfunction

   logic burst_req;
   assign burst_req = START && ((S == ModeRight) || (S == ModeLeft));

   always_comb begin
      state_d    = state_q;
      q_d        = q_q;
      dir_left_d = dir_left_q;
      rot_d      = rot_q;
      rem_d      = rem_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (burst_req) begin
               // The START edge only arms the engine; Q is untouched.
               if (CNT != '0) begin
                  state_d    = StRun;
                  dir_left_d = (S == ModeLeft);
                  rot_d      = ROT;
                  rem_d      = CNT;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               unique case (S)
                  ModeHold:  q_d = q_q;
                  ModeRight: q_d = shift_once(q_q, 1'b0, ROT, SR, SL);
                  ModeLeft:  q_d = shift_once(q_q, 1'b1, ROT, SR, SL);
                  ModeLoad:  q_d = D;
                  default:   q_d = q_q;
               endcase
            end
         end

         StRun: begin
            // Serial inputs stay live during a non-rotating burst.
            q_d   = shift_once(q_q, dir_left_q, rot_q, SR, SL);
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         state_q    <= StIdle;
         q_q        <= '0;
         dir_left_q <= 1'b0;
         rot_q      <= 1'b0;
         rem_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         q_q        <= q_d;
         dir_left_q <= dir_left_d;
         rot_q      <= rot_d;
         rem_q      <= rem_d;
         done_q     <= done_d;
      end
   end

   assign Q    = q_q;
   assign QR   = q_q[0];
   assign QL   = q_q[WIDTH-1];
   assign BUSY = (state_q == StRun);
   assign DONE = done_q;

`ifdef USR_PARITY_EN
   assign PAR = ^q_q;
`endif

endmodule
